pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch/decode/execute sequencer that drives program_counter (pc_inc, pc_load, pc_next).
//  Runs the instruction-memory fetch handshake and resolves jump/branch/call/return.
//  Holds a hardware return-address stack and enforces boot-region protection.
//  Sits between the decoder/ALU and program_counter in the 8-bit uC core.
// PARAMETERS
//  ADDR_WIDTH   12      PC/target width; must match program_counter
//  STACK_DEPTH  8       return-address stack entries (power of 2, >=2)
//  BOOT_END     12'h200 first non-boot address; [0,BOOT_END) is the strapping region
//  IRQ_VECTOR   12'h200 interrupt entry address (IRQ_EN builds only)
// PORTS
//  clk           in  1   core clock
//  arst_n        in  1   asynchronous active-low reset
//  clk_valid     in  1   global enable; when 0 state, stack and flags hold
//  pc_in         in  AW  current program_counter.pc_out
//  bootstrapping in  1   program_counter.bootstrapping
//  imem_req      out 1   fetch request; held high until imem_ack
//  imem_ack      in  1   instruction memory data valid
//  ir_load       out 1   1-cycle strobe: latch instruction register
//  dec_jump/dec_branch/dec_call/dec_ret  in 1 each  decoder flow-control class
//  branch_taken  in  1   ALU condition result for dec_branch
//  target        in  AW  jump/branch/call destination
//  exec_done     in  1   multi-cycle execute complete
//  halt_req      in  1   stop after current instruction
//  pc_inc        out 1   to program_counter
//  pc_load       out 1   to program_counter
//  pc_next       out AW  to program_counter
//  stk_ovf       out 1   sticky: push attempted while stack full
//  stk_unf       out 1   sticky: ret while stack empty
//  prot_err      out 1   sticky: non-boot code targeted the boot region
//  state         out 2   current FSM state (debug)
// BEHAVIOUR
//  Reset: state=FETCH, stack empty, all outputs 0, all flags 0. Reset is honoured mid-fetch or mid-stack op.
//  All transitions and stack/flag updates happen only on clk edges with clk_valid=1.
//  FETCH(0): imem_req=1. On imem_ack: ir_load=1 that cycle; next state DECODE. Fetch latency >=1 cycle.
//  DECODE(1): exactly one of pc_inc/pc_load is high for one cycle.
//   Priority: dec_ret > dec_call > dec_jump > (dec_branch & branch_taken); otherwise pc_inc.
//   ret: pc_load, pc_next=top of stack, pop. If stack empty: set stk_unf, pc_inc instead.
//   call: push (pc_in+1) mod 2^AW (0xFFF wraps to 0x000); pc_load target.
//    If stack full: set stk_ovf, push dropped, load still taken.
//   Protection: if bootstrapping=0 and target<BOOT_END (jump/branch/call): set prot_err, pc_inc, no push.
//   Next state EXECUTE.
//  EXECUTE(2): wait for exec_done. On exec_done: HALT if halt_req, else FETCH.
//  HALT(3): no strobes. Return to FETCH on the first cycle halt_req=0.
//  Flags clear only on reset.
// CONFIGURATION
//  UC_PC_SEQ_IRQ_EN defined: adds ports irq(in) and irq_ack(out 1-cycle).
//   On EXECUTE exit to FETCH with irq=1, not masked and bootstrapping=0, the cycle
//   performs a push of pc_in, pc_load IRQ_VECTOR and irq_ack=1, then masks further irq.
//   The next ret unmasks. halt_req has priority over irq.
//  Undefined: irq/irq_ack ports absent; behaviour is exactly the base FSM.
// STRUCTURE
//  Package uc_pkg: ADDR_WIDTH, BOOT_END, IRQ_VECTOR, and the state encoding localparams
//  (FETCH=0, DECODE=1, EXECUTE=2, HALT=3), shared with decoder and program_counter.
//  Sub-module call_stack: LIFO of STACK_DEPTH x ADDR_WIDTH.
//   Ports: push, pop, din, dout, full, empty. Simultaneous push+pop is never issued.
//  The FSM, priority mux and flags stay in pc_sequencer.
// TESTING
//  Reset, then straight-line code: imem_ack after 2 cycles -> ir_load 1 cycle, pc_inc once per instruction, pc_load=0.
//  Call at pc_in=0x210 with target=0x300, then ret -> loads 0x300, then 0x211; stack returns to empty.
//  Nine nested calls with STACK_DEPTH=8 -> 9th sets stk_ovf and still loads target. Ret on empty -> stk_unf and pc_inc.
//  bootstrapping=0 with jump target=0x050 -> prot_err=1, pc_inc. Same jump with bootstrapping=1 -> pc_load 0x050.
//  clk_valid=0 for 3 cycles mid-FETCH, and arst_n pulsed during DECODE -> state frozen, then clean reset to FETCH.
//  IRQ_EN: irq=1 at exec_done with pc_in=0x240 -> irq_ack, pc_next=0x200, push 0x240. Ret -> 0x240, irq unmasked.

Source files
------------

// File: rtl/uc_pkg.sv
`default_nettype none
// uc_pkg: core-wide address constants and the sequencer state encoding. Rev 1.0
// Shared by pc_sequencer, the decoder and program_counter.
package uc_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam logic [11:0] BOOT_END   = 12'h200;
  localparam logic [11:0] IRQ_VECTOR = 12'h200;

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] DECODE  = 2'd1;
  localparam logic [1:0] EXECUTE = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH   = FETCH,
    ST_DECODE  = DECODE,
    ST_EXECUTE = EXECUTE,
    ST_HALT    = HALT
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// call_stack: DEPTH x WIDTH LIFO holding return addresses. Rev 1.0
// Push while full and pop while empty are ignored; push and pop never coincide.
module call_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      cnt_q;
  logic [PW-1:0]    top_idx;

  // When full the low bits are zero, so the decrement wraps to DEPTH-1.
  assign top_idx = cnt_q[PW-1:0] - PW'(1);
  assign dout    = mem_q[top_idx];
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[cnt_q[PW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: fetch/decode/execute sequencer driving program_counter, with return stack. Rev 1.0
// Define UC_PC_SEQ_IRQ_EN to add the irq/irq_ack interrupt entry path.
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = uc_pkg::ADDR_WIDTH,
  parameter int unsigned           STACK_DEPTH = 8,
`ifdef UC_PC_SEQ_IRQ_EN
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = uc_pkg::IRQ_VECTOR,
`endif
  parameter logic [ADDR_WIDTH-1:0] BOOT_END    = uc_pkg::BOOT_END
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clk_valid,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  bootstrapping,
  output logic                  imem_req,
  input  logic                  imem_ack,
  output logic                  ir_load,
  input  logic                  dec_jump,
  input  logic                  dec_branch,
  input  logic                  dec_call,
  input  logic                  dec_ret,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  exec_done,
  input  logic                  halt_req,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  stk_ovf,
  output logic                  stk_unf,
  output logic                  prot_err,
`ifdef UC_PC_SEQ_IRQ_EN
  input  logic                  irq,
  output logic                  irq_ack,
`endif
  output logic [1:0]            state
);

  import uc_pkg::*;

  seq_state_e            state_q;
  logic                  imem_req_q;
  logic                  stk_ovf_q, stk_ovf_d;
  logic                  stk_unf_q, stk_unf_d;
  logic                  prot_err_q, prot_err_d;
  logic                  push, pop, full, empty;
  logic [ADDR_WIDTH-1:0] push_data, stk_top;
  logic                  prot_hit;
`ifdef UC_PC_SEQ_IRQ_EN
  logic                  irq_mask_q, irq_mask_d;
`endif

  assign prot_hit = !bootstrapping && (target < BOOT_END);

  always_comb begin
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_next    = '0;
    push       = 1'b0;
    pop        = 1'b0;
    push_data  = pc_in + ADDR_WIDTH'(1);
    stk_ovf_d  = stk_ovf_q;
    stk_unf_d  = stk_unf_q;
    prot_err_d = prot_err_q;
`ifdef UC_PC_SEQ_IRQ_EN
    irq_ack    = 1'b0;
    irq_mask_d = irq_mask_q;
`endif
    if (clk_valid) begin
      unique case (state_q)
        ST_DECODE: begin
          if (dec_ret) begin
`ifdef UC_PC_SEQ_IRQ_EN
            irq_mask_d = 1'b0;
`endif
            if (empty) begin
              stk_unf_d = 1'b1;
              pc_inc    = 1'b1;
            end else begin
              pc_load = 1'b1;
              pc_next = stk_top;
              pop     = 1'b1;
            end
          end else if (dec_call || dec_jump || (dec_branch && branch_taken)) begin
            if (prot_hit) begin
              prot_err_d = 1'b1;
              pc_inc     = 1'b1;
            end else begin
              pc_load = 1'b1;
              pc_next = target;
              // A call into a full stack still redirects; only the return address is lost.
              if (dec_call) begin
                if (full) stk_ovf_d = 1'b1;
                else      push      = 1'b1;
              end
            end
          end else begin
            pc_inc = 1'b1;
          end
        end
`ifdef UC_PC_SEQ_IRQ_EN
        ST_EXECUTE: begin
          if (exec_done && !halt_req && irq && !irq_mask_q && !bootstrapping) begin
            pc_load    = 1'b1;
            pc_next    = IRQ_VECTOR;
            push_data  = pc_in;
            irq_ack    = 1'b1;
            irq_mask_d = 1'b1;
            if (full) stk_ovf_d = 1'b1;
            else      push      = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_FETCH;
      imem_req_q <= 1'b0;
      stk_ovf_q  <= 1'b0;
      stk_unf_q  <= 1'b0;
      prot_err_q <= 1'b0;
`ifdef UC_PC_SEQ_IRQ_EN
      irq_mask_q <= 1'b0;
`endif
    end else if (clk_valid) begin
      stk_ovf_q  <= stk_ovf_d;
      stk_unf_q  <= stk_unf_d;
      prot_err_q <= prot_err_d;
`ifdef UC_PC_SEQ_IRQ_EN
      irq_mask_q <= irq_mask_d;
`endif
      unique case (state_q)
        ST_FETCH: begin
          // Request drops out of reset and is raised on the first enabled edge.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: state_q <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (exec_done) begin
            if (halt_req) begin
              state_q <= ST_HALT;
            end else begin
              state_q    <= ST_FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (!halt_req) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign imem_req = imem_req_q;
  assign ir_load  = clk_valid && (state_q == ST_FETCH) && imem_req_q && imem_ack;
  assign stk_ovf  = stk_ovf_q;
  assign stk_unf  = stk_unf_q;
  assign prot_err = prot_err_q;
  assign state    = state_q;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_call_stack (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .dout   (stk_top),
    .full   (full),
    .empty  (empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pc_sequencer: randomized instruction stream scored against a queue-based flow model.
module tb_pc_sequencer;

  localparam int DEPTH  = 8;
  localparam int K_NOP  = 0;
  localparam int K_JMP  = 1;
  localparam int K_BR   = 2;
  localparam int K_CALL = 3;
  localparam int K_RET  = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        clk_valid = 1'b1;
  logic [11:0] pc_in = '0;
  logic        bootstrapping = 1'b1;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        ir_load;
  logic        dec_jump = 1'b0, dec_branch = 1'b0, dec_call = 1'b0, dec_ret = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] target = '0;
  logic        exec_done = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_inc, pc_load;
  logic [11:0] pc_next;
  logic        stk_ovf, stk_unf, prot_err;
  logic [1:0]  state;
`ifdef UC_PC_SEQ_IRQ_EN
  logic        irq = 1'b0;
  logic        irq_ack;
`endif

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .clk_valid     (clk_valid),
    .pc_in         (pc_in),
    .bootstrapping (bootstrapping),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .ir_load       (ir_load),
    .dec_jump      (dec_jump),
    .dec_branch    (dec_branch),
    .dec_call      (dec_call),
    .dec_ret       (dec_ret),
    .branch_taken  (branch_taken),
    .target        (target),
    .exec_done     (exec_done),
    .halt_req      (halt_req),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .stk_ovf       (stk_ovf),
    .stk_unf       (stk_unf),
    .prot_err      (prot_err),
`ifdef UC_PC_SEQ_IRQ_EN
    .irq           (irq),
    .irq_ack       (irq_ack),
`endif
    .state         (state)
  );

  typedef struct {
    logic        load;
    logic [11:0] nxt;
    logic        ovf;
    logic        unf;
    logic        prot;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] m_stk[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_prot = 1'b0;
  int          checks = 0, errors = 0, ir_seen = 0, instr_sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_prot = 1'b0;
  endtask

  // Architectural effect of one decoded instruction on PC flow, stack and flags.
  task automatic predict(input int kind, input logic [11:0] pc, input logic [11:0] tgt,
                         input logic boot, input logic taken);
    exp_t e;
    logic redirect;
    e.load   = 1'b0;
    e.nxt    = '0;
    redirect = (kind == K_JMP) || (kind == K_CALL) || (kind == K_BR && taken);
    if (kind == K_RET) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else begin
        e.load = 1'b1;
        e.nxt  = m_stk.pop_back();
      end
    end else if (redirect) begin
      if (!boot && tgt < 12'h200) m_prot = 1'b1;
      else begin
        e.load = 1'b1;
        e.nxt  = tgt;
        if (kind == K_CALL) begin
          if (m_stk.size() >= DEPTH) m_ovf = 1'b1;
          else m_stk.push_back(pc + 12'd1);
        end
      end
    end
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.prot = m_prot;
    sb_q.push_back(e);
  endtask

  task automatic run_instr(input int kind, input logic [11:0] pc, input logic [11:0] tgt,
                           input logic boot, input logic taken, input logic halt, input int lat);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: imem_req=%b, expected 1 within 50 cycles", imem_req);
      return;
    end
    repeat (lat) tick();
    pc_in         = pc;
    target        = tgt;
    bootstrapping = boot;
    branch_taken  = taken;
    dec_jump      = (kind == K_JMP);
    dec_branch    = (kind == K_BR);
    dec_call      = (kind == K_CALL);
    dec_ret       = (kind == K_RET);
    imem_ack      = 1'b1;
    predict(kind, pc, tgt, boot, taken);
    instr_sent++;
    tick();
    imem_ack = 1'b0;
    tick();
    dec_jump = 1'b0; dec_branch = 1'b0; dec_call = 1'b0; dec_ret = 1'b0;
    branch_taken = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    exec_done = 1'b1;
    halt_req  = halt;
    tick();
    exec_done = 1'b0;
    if (halt) begin
      repeat (2) begin
        chk("halt_state", {imem_req, state}, 3'b011);
        tick();
      end
      halt_req = 1'b0;
      tick();
    end
  endtask

  // Monitor: scores every PC strobe and the sticky flags one edge later.
  exp_t cur;
  logic flag_pend = 1'b0;
  always @(negedge clk) begin
    if (flag_pend) begin
      chk("flags", {stk_ovf, stk_unf, prot_err}, {cur.ovf, cur.unf, cur.prot});
      flag_pend = 1'b0;
    end
    if (arst_n && (pc_inc || pc_load)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: pc_inc=%b pc_load=%b, expected no strobe", pc_inc, pc_load);
      end else begin
        cur = sb_q.pop_front();
        chk("strobe_state", state, 32'd1);
        chk("pc_inc_load", {pc_inc, pc_load}, {!cur.load, cur.load});
        chk("pc_next", pc_next, cur.nxt);
        flag_pend = 1'b1;
      end
    end
    if (ir_load) begin
      ir_seen++;
      chk("ir_load_handshake", {imem_req, imem_ack, clk_valid}, 3'b111);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] r_pc, r_tgt;
    int          r_kind;

    // Reset state
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {imem_req, ir_load, pc_inc, pc_load, pc_next, stk_ovf, stk_unf, prot_err, state}, 0);
    tick();
    arst_n = 1'b1;
    model_reset();

    // Straight-line code with two-cycle fetch latency
    for (int i = 0; i < 3; i++) run_instr(K_NOP, 12'h200 + 12'(i), 12'h000, 1'b1, 1'b0, 1'b0, 2);

    // Call/return pair
    run_instr(K_CALL, 12'h210, 12'h300, 1'b0, 1'b0, 1'b0, 1);
    run_instr(K_RET,  12'h300, 12'h000, 1'b0, 1'b0, 1'b0, 1);

    // Nine nested calls overflow the eight-entry stack, then unwind past empty
    for (int i = 0; i < 9; i++) run_instr(K_CALL, 12'h400 + 12'(i * 4), 12'h500 + 12'(i), 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 9; i++) run_instr(K_RET, 12'h600, 12'h000, 1'b1, 1'b0, 1'b0, 0);

    // Return address wraps at the top of the address space
    run_instr(K_CALL, 12'hFFF, 12'h300, 1'b1, 1'b0, 1'b0, 0);
    run_instr(K_RET,  12'h300, 12'h000, 1'b1, 1'b0, 1'b0, 0);

    // Boot-region protection and its edges
    run_instr(K_JMP, 12'h220, 12'h050, 1'b0, 1'b0, 1'b0, 1);
    run_instr(K_JMP, 12'h220, 12'h050, 1'b1, 1'b0, 1'b0, 1);
    run_instr(K_JMP, 12'h220, 12'h200, 1'b0, 1'b0, 1'b0, 0);
    run_instr(K_BR,  12'h220, 12'h010, 1'b0, 1'b0, 1'b0, 0);
    run_instr(K_NOP, 12'h221, 12'h000, 1'b1, 1'b0, 1'b1, 0);

    // Freeze mid-fetch, then reset while in DECODE
    while (imem_req !== 1'b1) tick();
    clk_valid = 1'b0;
    imem_ack  = 1'b1;
    repeat (3) begin
      tick();
      chk("freeze_hold", {state, imem_req, ir_load}, {2'd0, 1'b1, 1'b0});
    end
    dec_jump      = 1'b1;
    target        = 12'h300;
    bootstrapping = 1'b1;
    clk_valid     = 1'b1;
    instr_sent++;
    tick();
    imem_ack = 1'b0;
    chk("freeze_release_decode", state, 32'd1);
    arst_n = 1'b0;
    #1;
    chk("reset_mid_decode", {imem_req, ir_load, pc_inc, pc_load, pc_next, stk_ovf, stk_unf, prot_err, state}, 0);
    dec_jump = 1'b0;
    model_reset();
    tick();
    arst_n = 1'b1;

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      r_kind = $urandom_range(0, 4);
      r_pc   = 12'($urandom_range(0, 4095));
      r_tgt  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 511)) : 12'($urandom_range(0, 4095));
      run_instr(r_kind, r_pc, r_tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end

    repeat (3) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("ir_load_count", ir_seen, instr_sent);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
